// File: rtl/wb_arbiter_if.sv
// Bundle of handshake and register-file write signals for the writeback arbiter.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_vld_i;
  logic              alu_rdy_o;
  logic [ADDR_W-1:0] alu_rd_addr_i;
  logic [DATA_W-1:0] alu_rd_data_i;
  logic              lsu_vld_i;
  logic              lsu_rdy_o;
  logic [ADDR_W-1:0] lsu_rd_addr_i;
  logic [DATA_W-1:0] lsu_rd_data_i;
  logic [2:0]        lsu_funct3_i;
  logic [1:0]        lsu_byte_off_i;
  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic              hazard_o;
  logic              busy_o;
  logic              regs_wr_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_o;

  modport slave (
    input  alu_vld_i, alu_rd_addr_i, alu_rd_data_i,
    input  lsu_vld_i, lsu_rd_addr_i, lsu_rd_data_i, lsu_funct3_i, lsu_byte_off_i,
    input  rs1_addr_i, rs2_addr_i,
    output alu_rdy_o, lsu_rdy_o, hazard_o, busy_o,
    output regs_wr_en_o, rd_addr_o, rd_data_o
  );

  modport master (
    output alu_vld_i, alu_rd_addr_i, alu_rd_data_i,
    output lsu_vld_i, lsu_rd_addr_i, lsu_rd_data_i, lsu_funct3_i, lsu_byte_off_i,
    output rs1_addr_i, rs2_addr_i,
    input  alu_rdy_o, lsu_rdy_o, hazard_o, busy_o,
    input  regs_wr_en_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two small FIFOs (ALU, LSU) merged round-robin into the
// single register-file write port, with load extension and a hazard lookup.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] alu_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] alu_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] alu_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] alu_data_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] lsu_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] lsu_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] lsu_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] lsu_data_d [FIFO_DEPTH];

  logic [PTR_W-1:0]  alu_wr_ptr_q, alu_wr_ptr_d, alu_rd_ptr_q, alu_rd_ptr_d;
  logic [PTR_W-1:0]  lsu_wr_ptr_q, lsu_wr_ptr_d, lsu_rd_ptr_q, lsu_rd_ptr_d;
  logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d, lsu_cnt_q, lsu_cnt_d;
  logic              last_lsu_q, last_lsu_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic alu_empty, lsu_empty, alu_rdy, lsu_rdy;
  logic alu_push, lsu_push, alu_pop, lsu_pop;
  logic hazard;

  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] raw,
    input logic [2:0]        funct3,
    input logic [1:0]        off
  );
    logic [DATA_W-1:0] byte_sh, half_sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    byte_sh = raw >> {off, 3'b000};
    half_sh = raw >> {off[1], 4'b0000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    case (funct3)
      3'b000:  load_extend = {{(DATA_W-8){b[7]}}, b};
      3'b100:  load_extend = {{(DATA_W-8){1'b0}}, b};
      3'b001:  load_extend = {{(DATA_W-16){h[15]}}, h};
      3'b101:  load_extend = {{(DATA_W-16){1'b0}}, h};
      default: load_extend = raw;
    endcase
  endfunction

  function automatic logic addr_hit(
    input logic [ADDR_W-1:0] rd,
    input logic [ADDR_W-1:0] rs1,
    input logic [ADDR_W-1:0] rs2
  );
    addr_hit = (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Stage: FIFO push/pop and round-robin selection
  always_comb begin
    alu_empty = (alu_cnt_q == '0);
    lsu_empty = (lsu_cnt_q == '0);
    alu_rdy   = (alu_cnt_q != FULL_CNT) && rst_ni;
    lsu_rdy   = (lsu_cnt_q != FULL_CNT) && rst_ni;
    alu_push  = bus.alu_vld_i && alu_rdy;
    lsu_push  = bus.lsu_vld_i && lsu_rdy;
    lsu_pop   = !lsu_empty && (alu_empty || !last_lsu_q);
    alu_pop   = !alu_empty && !lsu_pop;

    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    lsu_addr_d = lsu_addr_q;
    lsu_data_d = lsu_data_q;
    if (alu_push) begin
      alu_addr_d[alu_wr_ptr_q] = bus.alu_rd_addr_i;
      alu_data_d[alu_wr_ptr_q] = bus.alu_rd_data_i;
    end
    if (lsu_push) begin
      lsu_addr_d[lsu_wr_ptr_q] = bus.lsu_rd_addr_i;
      lsu_data_d[lsu_wr_ptr_q] = load_extend(bus.lsu_rd_data_i, bus.lsu_funct3_i,
                                             bus.lsu_byte_off_i);
    end

    alu_wr_ptr_d = alu_push ? alu_wr_ptr_q + PTR_W'(1) : alu_wr_ptr_q;
    lsu_wr_ptr_d = lsu_push ? lsu_wr_ptr_q + PTR_W'(1) : lsu_wr_ptr_q;
    alu_rd_ptr_d = alu_pop  ? alu_rd_ptr_q + PTR_W'(1) : alu_rd_ptr_q;
    lsu_rd_ptr_d = lsu_pop  ? lsu_rd_ptr_q + PTR_W'(1) : lsu_rd_ptr_q;
    alu_cnt_d    = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_pop);
    lsu_cnt_d    = lsu_cnt_q + CNT_W'(lsu_push) - CNT_W'(lsu_pop);
    last_lsu_d   = (!alu_empty && !lsu_empty) ? lsu_pop : last_lsu_q;
  end

  // Stage: register-file write register
  always_comb begin
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (lsu_pop) begin
      rd_addr_d = lsu_addr_q[lsu_rd_ptr_q];
      rd_data_d = lsu_data_q[lsu_rd_ptr_q];
      wr_en_d   = (rd_addr_d != '0);
    end else if (alu_pop) begin
      rd_addr_d = alu_addr_q[alu_rd_ptr_q];
      rd_data_d = alu_data_q[alu_rd_ptr_q];
      wr_en_d   = (rd_addr_d != '0);
    end
  end

  // Hazard lookup scans only the occupied slots, walking from each head
  always_comb begin
    hazard = wr_en_q && addr_hit(rd_addr_q, bus.rs1_addr_i, bus.rs2_addr_i);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CNT_W'(i) < alu_cnt_q) &&
          addr_hit(alu_addr_q[alu_rd_ptr_q + PTR_W'(i)], bus.rs1_addr_i, bus.rs2_addr_i))
        hazard = 1'b1;
      if ((CNT_W'(i) < lsu_cnt_q) &&
          addr_hit(lsu_addr_q[lsu_rd_ptr_q + PTR_W'(i)], bus.rs1_addr_i, bus.rs2_addr_i))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    alu_addr_q <= alu_addr_d;
    alu_data_q <= alu_data_d;
    lsu_addr_q <= lsu_addr_d;
    lsu_data_q <= lsu_data_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      alu_wr_ptr_q <= '0;
      alu_rd_ptr_q <= '0;
      lsu_wr_ptr_q <= '0;
      lsu_rd_ptr_q <= '0;
      alu_cnt_q    <= '0;
      lsu_cnt_q    <= '0;
      last_lsu_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      alu_wr_ptr_q <= alu_wr_ptr_d;
      alu_rd_ptr_q <= alu_rd_ptr_d;
      lsu_wr_ptr_q <= lsu_wr_ptr_d;
      lsu_rd_ptr_q <= lsu_rd_ptr_d;
      alu_cnt_q    <= alu_cnt_d;
      lsu_cnt_q    <= lsu_cnt_d;
      last_lsu_q   <= last_lsu_d;
      wr_en_q      <= wr_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.alu_rdy_o    = alu_rdy;
  assign bus.lsu_rdy_o    = lsu_rdy;
  assign bus.hazard_o     = hazard;
  assign bus.busy_o       = !alu_empty || !lsu_empty || wr_en_q;
  assign bus.regs_wr_en_o = wr_en_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model feeds an expected-write
// scoreboard drained by a negedge monitor, plus directed scenario checks.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t alu_q[$];
  ent_t lsu_q[$];
  ent_t exp_q[$];
  bit            m_last = 1'b0;
  bit            m_out_en = 1'b0;
  logic [AW-1:0] m_out_addr = '0;
  bit            acc_a, acc_l;
  bit            mon_on = 1'b0;
  int            vecs = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load extension written as plain arithmetic on the raw word
  function automatic logic [31:0] ref_ext(input logic [31:0] raw, input logic [2:0] f3,
                                          input logic [1:0] off);
    longint unsigned r, v;
    int o;
    r = raw;
    o = int'(off);
    case (f3)
      3'd0: begin v = (r >> (8 * o)) % 256;       return (v >= 128)   ? 32'(v) - 32'd256   : 32'(v); end
      3'd4: begin v = (r >> (8 * o)) % 256;       return 32'(v); end
      3'd1: begin v = (r >> (16 * (o / 2))) % 65536; return (v >= 32768) ? 32'(v) - 32'd65536 : 32'(v); end
      3'd5: begin v = (r >> (16 * (o / 2))) % 65536; return 32'(v); end
      default: return raw;
    endcase
  endfunction

  function automatic bit hits(input logic [AW-1:0] a, input logic [AW-1:0] r1,
                              input logic [AW-1:0] r2);
    return (a != 0) && (a == r1 || a == r2);
  endfunction

  function automatic bit m_hazard(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit h;
    h = m_out_en && hits(m_out_addr, r1, r2);
    foreach (alu_q[i]) if (hits(alu_q[i].addr, r1, r2)) h = 1'b1;
    foreach (lsu_q[i]) if (hits(lsu_q[i].addr, r1, r2)) h = 1'b1;
    return h;
  endfunction

  // One clock edge: decide acceptance from the model, then update the model
  task automatic cycle();
    ent_t ea, el, e;
    bit pa, pl;
    acc_a = rst_ni && bus.alu_vld_i && (alu_q.size() < DEPTH);
    acc_l = rst_ni && bus.lsu_vld_i && (lsu_q.size() < DEPTH);
    ea = '{addr: bus.alu_rd_addr_i, data: bus.alu_rd_data_i};
    el = '{addr: bus.lsu_rd_addr_i,
           data: ref_ext(bus.lsu_rd_data_i, bus.lsu_funct3_i, bus.lsu_byte_off_i)};
    @(posedge clk);
    if (!rst_ni) begin
      alu_q.delete();
      lsu_q.delete();
      m_last = 1'b0;
      m_out_en = 1'b0;
      m_out_addr = '0;
    end else begin
      if (alu_q.size() > 0 && lsu_q.size() > 0) begin
        pl = !m_last;
        pa = m_last;
        m_last = pl;
      end else begin
        pa = (alu_q.size() > 0);
        pl = (lsu_q.size() > 0);
      end
      m_out_en = 1'b0;
      if (pa || pl) begin
        if (pl) e = lsu_q.pop_front();
        else    e = alu_q.pop_front();
        m_out_addr = e.addr;
        m_out_en = (e.addr != 0);
        if (m_out_en) exp_q.push_back(e);
      end
      if (acc_a) alu_q.push_back(ea);
      if (acc_l) lsu_q.push_back(el);
    end
    #1;
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (mon_on) begin
      chk("alu_rdy", 32'(bus.alu_rdy_o), 32'(rst_ni && alu_q.size() < DEPTH));
      chk("lsu_rdy", 32'(bus.lsu_rdy_o), 32'(rst_ni && lsu_q.size() < DEPTH));
      chk("busy", 32'(bus.busy_o), 32'(alu_q.size() > 0 || lsu_q.size() > 0 || m_out_en));
      chk("hazard", 32'(bus.hazard_o), 32'(m_hazard(bus.rs1_addr_i, bus.rs2_addr_i)));
      if (bus.regs_wr_en_o) begin
        if (exp_q.size() == 0) begin
          vecs++; fails++;
          $display("FAIL wr_unexpected: got write rd=%0d data=%h, expected none", bus.rd_addr_o, bus.rd_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.rd_addr_o), 32'(e.addr));
          chk("wr_data", bus.rd_data_o, e.data);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vecs++; fails++;
        $display("FAIL wr_missing: got no write, expected rd=%0d data=%h", e.addr, e.data);
      end
    end
  end

  task automatic set_alu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.alu_vld_i = v; bus.alu_rd_addr_i = a; bus.alu_rd_data_i = d;
  endtask

  task automatic set_lsu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [2:0] f3, input logic [1:0] off);
    bus.lsu_vld_i = v; bus.lsu_rd_addr_i = a; bus.lsu_rd_data_i = d;
    bus.lsu_funct3_i = f3; bus.lsu_byte_off_i = off;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  lf3 [5];
    logic [1:0]  loff[5];
    logic [31:0] lexp[5];
    logic [4:0]  cseq[4];
    int sent;
    bit dropped;
    lf3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    loff = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    lexp = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    cseq = '{5'd20, 5'd10, 5'd21, 5'd11};

    set_alu(0, 0, 0);
    set_lsu(0, 0, 0, 0, 0);
    bus.rs1_addr_i = 5'd5;
    bus.rs2_addr_i = 5'd0;

    // Reset state
    cycle();
    cycle();
    chk("rst_wr_en", 32'(bus.regs_wr_en_o), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr_o), 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_hazard", 32'(bus.hazard_o), 0);
    chk("rst_alu_rdy_low", 32'(bus.alu_rdy_o), 0);
    chk("rst_lsu_rdy_low", 32'(bus.lsu_rdy_o), 0);
    rst_ni = 1'b1;
    #1;
    chk("alu_rdy_after_rst", 32'(bus.alu_rdy_o), 1);
    chk("lsu_rdy_after_rst", 32'(bus.lsu_rdy_o), 1);
    mon_on = 1'b1;

    // Single ALU write with latency and hazard window
    set_alu(1, 5'd5, 32'hDEADBEEF);
    cycle();
    set_alu(0, 0, 0);
    chk("single_hazard_queued", 32'(bus.hazard_o), 1);
    chk("single_no_write_yet", 32'(bus.regs_wr_en_o), 0);
    cycle();
    chk("single_wr_en", 32'(bus.regs_wr_en_o), 1);
    chk("single_rd_addr", 32'(bus.rd_addr_o), 5);
    chk("single_rd_data", bus.rd_data_o, 32'hDEADBEEF);
    chk("single_hazard_out", 32'(bus.hazard_o), 1);
    cycle();
    chk("single_wr_done", 32'(bus.regs_wr_en_o), 0);
    chk("single_hazard_clear", 32'(bus.hazard_o), 0);
    bus.rs1_addr_i = 5'd0;

    // Load extension
    for (int i = 0; i < 5; i++) begin
      set_lsu(1, 5'(i + 1), 32'h8899AABB, lf3[i], loff[i]);
      cycle();
      set_lsu(0, 0, 0, 0, 0);
      cycle();
      chk("load_wr_en", 32'(bus.regs_wr_en_o), 1);
      chk("load_data", bus.rd_data_o, lexp[i]);
    end
    cycle();

    // Contention: both sources push two entries at the same edges
    set_alu(1, 5'd10, 32'hA0);
    set_lsu(1, 5'd20, 32'hB0, 3'b010, 0);
    cycle();
    set_alu(1, 5'd11, 32'hA1);
    set_lsu(1, 5'd21, 32'hB1, 3'b010, 0);
    cycle();
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("contend_wr_en", 32'(bus.regs_wr_en_o), 1);
      chk("contend_order", 32'(bus.rd_addr_o), 32'(cseq[k]));
      cycle();
    end
    repeat (3) cycle();

    // Backpressure: ALU held valid while LSU streams
    sent = 0;
    dropped = 1'b0;
    set_alu(1, 5'd12, 32'hC0);
    set_lsu(1, 5'd13, 32'hD0, 3'b010, 0);
    for (int c = 0; c < 40 && sent < 4; c++) begin
      if (!bus.alu_rdy_o) dropped = 1'b1;
      cycle();
      if (acc_a) begin
        sent++;
        set_alu(1, 5'd12, 32'hC0 + 32'(sent));
      end
      if (acc_l) set_lsu(1, 5'd13, bus.lsu_rd_data_i + 1, 3'b010, 0);
    end
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0, 0, 0);
    chk("bp_all_accepted", 32'(sent), 4);
    chk("bp_rdy_dropped", 32'(dropped), 1);
    repeat (8) cycle();

    // x0 destination is consumed without a write
    bus.rs1_addr_i = 5'd0;
    bus.rs2_addr_i = 5'd0;
    set_alu(1, 5'd0, 32'h1234);
    cycle();
    set_alu(0, 0, 0);
    chk("x0_hazard_queued", 32'(bus.hazard_o), 0);
    chk("x0_busy_queued", 32'(bus.busy_o), 1);
    cycle();
    chk("x0_no_write", 32'(bus.regs_wr_en_o), 0);
    chk("x0_hazard_after", 32'(bus.hazard_o), 0);
    chk("x0_idle", 32'(bus.busy_o), 0);

    // Randomized traffic; an offered entry is held until accepted
    for (int c = 0; c < 400; c++) begin
      if (!bus.alu_vld_i || acc_a)
        set_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      if (!bus.lsu_vld_i || acc_l)
        set_lsu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      bus.rs1_addr_i = 5'($urandom_range(0, 7));
      bus.rs2_addr_i = 5'($urandom_range(0, 7));
      cycle();
    end
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0, 0, 0);
    repeat (6) cycle();

    // Mid-operation reset discards everything pending
    bus.rs1_addr_i = 5'd7;
    bus.rs2_addr_i = 5'd9;
    set_alu(1, 5'd7, 32'hE0);
    set_lsu(1, 5'd9, 32'hF0, 3'b010, 0);
    repeat (4) cycle();
    chk("midrst_busy_before", 32'(bus.busy_o), 1);
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    cycle();
    rst_ni = 1'b1;
    #1;
    chk("midrst_alu_rdy", 32'(bus.alu_rdy_o), 1);
    chk("midrst_lsu_rdy", 32'(bus.lsu_rdy_o), 1);
    chk("midrst_busy", 32'(bus.busy_o), 0);
    chk("midrst_hazard", 32'(bus.hazard_o), 0);
    chk("midrst_wr_en", 32'(bus.regs_wr_en_o), 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("midrst_no_write", 32'(bus.regs_wr_en_o), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the RV32I core: merges register-file write requests from the ALU path and the load/store unit (LSU) into the register file's single write port. Each source has a small FIFO with a valid/ready handshake. Load data is byte/halfword-aligned and sign/zero-extended on acceptance. A combinational hazard lookup tells decode when a source register still has a write in flight. The block sits between execute/memory and the register file and drives its `regs_wr_en_i`, `rd_addr_i` and `rd_data_i` inputs.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `FIFO_DEPTH`, 2, entries per source FIFO (power of two, ≥2)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low (`clk_i`, `rst_ni`).
- `clk_i` in 1: clock, rising edge
- `rst_ni` in 1: synchronous active-low reset
- `alu_vld_i` in 1: ALU write request valid
- `alu_rdy_o` out 1: ALU FIFO can accept
- `alu_rd_addr_i` in ADDR_W: ALU destination register
- `alu_rd_data_i` in DATA_W: ALU result
- `lsu_vld_i` in 1: load writeback valid
- `lsu_rdy_o` out 1: LSU FIFO can accept
- `lsu_rd_addr_i` in ADDR_W: load destination register
- `lsu_rd_data_i` in DATA_W: raw aligned memory word
- `lsu_funct3_i` in 3: load type
- `lsu_byte_off_i` in 2: address[1:0] of the load
- `rs1_addr_i`, `rs2_addr_i` in ADDR_W: decode-stage source registers
- `hazard_o` out 1: a pending write targets rs1 or rs2
- `busy_o` out 1: any entry pending or output valid
- `regs_wr_en_o` out 1: register-file write enable
- `rd_addr_o` out ADDR_W: register-file write address
- `rd_data_o` out DATA_W: register-file write data

## Operation
- Push: an entry is written into a FIFO on a rising edge where `vld_i && rdy_o`.
  - `rdy_o` = FIFO not full and `rst_ni` high.
  - No same-cycle pass-through: a full FIFO stays not-ready even in a cycle where it pops.
- Load extension happens at push time; the FIFO stores the final value.
  - funct3 000 (LB): byte `off` sign-extended.
  - 100 (LBU): byte `off` zero-extended.
  - 001 (LH): halfword `off[1]` sign-extended.
  - 101 (LHU): halfword `off[1]` zero-extended.
  - 010 and all other codes: full word unchanged.
  - For halfword loads, `off[0]` is ignored.
- Arbitration: one pop per cycle, driven by a round-robin flag `last_lsu`.
  - Only one FIFO non-empty: that FIFO pops.
  - Both non-empty: LSU pops if `last_lsu`=0, otherwise ALU.
  - `last_lsu` updates only when both were non-empty.
  - Reset value of `last_lsu` is 0, so LSU wins the first contest.
- Output register: loads on every edge.
  - On a pop: `regs_wr_en_o` = (addr != 0), with the popped addr/data.
  - Otherwise: `regs_wr_en_o` = 0; addr/data hold their previous values.
- x0 destination: the entry is still consumed; no write is issued.
- `hazard_o` (combinational):
  - 1 if any valid FIFO entry, or the output register while `regs_wr_en_o`=1, has a nonzero rd equal to `rs1_addr_i` or `rs2_addr_i`.
  - Never asserted for address 0.
- `busy_o` = either FIFO non-empty OR `regs_wr_en_o`.

## Timing
- Reset (`rst_ni`=0 at an edge):
  - Both FIFOs cleared; pointers and counts = 0.
  - `last_lsu`=0.
  - `regs_wr_en_o`=0, `rd_addr_o`=0, `rd_data_o`=0.
  - `alu_rdy_o`=`lsu_rdy_o`=0 while `rst_ni` is low.
  - `hazard_o`=`busy_o`=0 after the reset edge.
- Reset mid-operation: all pending entries are discarded; none is ever written.
- Latency, uncontested entry accepted at edge k:
  - Occupies the FIFO head in cycle k..k+1.
  - Popped at edge k+1.
  - `regs_wr_en_o` high for exactly the one cycle after edge k+1.
- Throughput: one register-file write per cycle total. Sustained dual-source traffic alternates sources.
- Simultaneous push and pop on the same FIFO: count is unchanged; pointers wrap modulo `FIFO_DEPTH`.
- Order: entries from a single source are written in acceptance order.
- Cross-source order follows the arbitration rules only. Decode uses `hazard_o` to prevent WAW/RAW conflicts.
- Empty FIFO never pops; full FIFO never overwrites.

## Test plan
- Reset then single ALU write:
  - Stimulus: `alu_vld_i`=1, rd=5, data=0xDEADBEEF accepted at edge 1.
  - Response: `regs_wr_en_o`=1, `rd_addr_o`=5, `rd_data_o`=0xDEADBEEF in the cycle after edge 2 only; `hazard_o`=1 for rs1=5 until that write cycle ends.
- Load extension:
  - Raw data 0x8899AABB with (LB, off 1) → 0xFFFFFFAA.
  - (LBU, off 3) → 0x00000088.
  - (LH, off 2) → 0xFFFF8899.
  - (LHU, off 0) → 0x0000AABB.
  - (LW) → 0x8899AABB.
- Contention:
  - Stimulus: both sources push 2 entries each at the same edges.
  - Response: write sequence is LSU0, ALU0, LSU1, ALU1 on four consecutive cycles.
- Backpressure:
  - Stimulus: hold `alu_vld_i` high for 4 edges while the LSU is also continuously valid.
  - Response: `alu_rdy_o` drops when the ALU FIFO holds 2 entries; no entry is lost or duplicated; all 4 ALU values are eventually written in order.
- x0 write:
  - Stimulus: ALU rd=0, data=0x1234.
  - Response: the entry is consumed, `regs_wr_en_o` stays 0, and `hazard_o` stays 0 for rs1=0.
- Mid-operation reset:
  - Stimulus: fill both FIFOs, then assert `rst_ni`=0 for one edge.
  - Response: no write occurs afterward; `busy_o`=0; both `rdy_o`=1 after `rst_ni` returns high.
